pin_entry_ctrl: RTL
===================

# pin_entry_ctrl

Keypad PIN collector that sits directly upstream of the ATM transaction state machine. Once a card is inserted, it gathers decimal key presses into a packed-BCD PIN and presents that PIN to the downstream checker through a valid/ready handshake. It then waits for the checker's accept or reject verdict, counts failed attempts, and retains the card once the retry budget is exhausted. An optional inactivity timeout aborts a stalled entry.

## Interface
- DIGITS, 4, number of PIN digits; legal range 1..15.
- MAX_TRIES, 3, number of failed verifications allowed; legal range 1..3.
- TIMEOUT, 1000, idle-cycle limit in COLLECT; only used when the timeout feature is compiled in.

Ports:
- clk  in  1  rising-edge clock; the single clock of the block.
- rst_n  in  1  synchronous, active-low reset.
- card_in  in  1  level signal; high while a card is inserted.
- key_valid  in  1  single-cycle keypad strobe.
- key_code  in  4  key code, sampled when key_valid=1.
  - 0x0–0x9: digit.
  - 0xA: clear.
  - 0xB: enter.
  - 0xC: cancel.
  - 0xD–0xF: reserved, ignored.
- pin_ready  in  1  downstream checker ready to take the PIN.
- pin_ok  in  1  single-cycle pulse: PIN accepted.
- pin_reject  in  1  single-cycle pulse: PIN rejected.
- pin_valid  out  1  PIN presented to downstream.
- pin_bcd  out  4*DIGITS  packed BCD, first-entered digit in the MS nibble.
- digit_count  out  4  number of digits currently buffered.
- attempts_left  out  2  remaining verification tries.
- card_retain  out  1  card swallowed; sticky until reset.
- timeout  out  1  one-cycle pulse on entry timeout.
- busy  out  1  high in COLLECT, PRESENT and WAIT_RESULT.

## Operation
- States: IDLE, COLLECT, PRESENT, WAIT_RESULT, DONE, LOCKED.
- Reset values:
  - state = IDLE.
  - pin_bcd = 0, digit_count = 0.
  - pin_valid = 0, card_retain = 0, timeout = 0, busy = 0.
  - attempts_left = MAX_TRIES.
- IDLE:
  - Clear the buffer and reload attempts_left = MAX_TRIES.
  - card_in=1 → COLLECT.
- COLLECT (key actions apply only when key_valid=1):
  - Digit with digit_count<DIGITS: pin_bcd = {pin_bcd[4*DIGITS-5:0], key_code}; digit_count+1.
  - Digit when the buffer is full: ignored, and the buffer is unchanged.
  - Clear (0xA): pin_bcd=0, digit_count=0.
  - Enter (0xB) with digit_count==DIGITS: → PRESENT.
  - Enter (0xB) with a short buffer: ignored.
  - Cancel (0xC): → IDLE.
- PRESENT:
  - pin_valid=1, and pin_bcd is held stable.
  - The cycle with pin_valid&&pin_ready completes the transfer → WAIT_RESULT.
  - pin_valid must not drop before the transfer completes.
- WAIT_RESULT:
  - pin_ok → DONE.
  - pin_reject → attempts_left−1, and the buffer is cleared.
    - If the result is 0 → LOCKED with card_retain=1.
    - Otherwise → COLLECT.
  - pin_ok and pin_reject in the same cycle: pin_ok wins.
- DONE:
  - Idle with the buffer cleared.
  - card_in=0 → IDLE.
- LOCKED:
  - card_retain=1 and busy=0.
  - Only rst_n leaves this state; card_in and keys are ignored.
- Card removal:
  - card_in=0 in COLLECT, PRESENT, WAIT_RESULT or DONE → IDLE on the next edge.
  - Card removal has priority over every other event in the same cycle, including enter, pin_ok and pin_reject.
- key_valid is ignored in every state except COLLECT.

## Timing
- All outputs are registered.
- The effect of an event sampled at edge N is visible after edge N.
- Digit key: pin_bcd and digit_count update 1 cycle after the strobe.
- Enter: pin_valid rises 1 cycle after the enter strobe.
- pin_valid falls in the cycle after the handshake cycle.
- Verdict: state and attempts_left update 1 cycle after the pulse.
- Back-to-back key strobes on consecutive cycles are all accepted.
- Reset mid-operation: the next edge with rst_n=0 forces the reset values, from any state including LOCKED.

## Configuration
- PIN_TIMEOUT_EN defined:
  - A cycle counter runs in COLLECT only.
  - The counter zeroes on COLLECT entry and on every key_valid, whatever the code.
  - When TIMEOUT consecutive cycles pass with no key_valid: timeout pulses for 1 cycle and the state → IDLE.
- PIN_TIMEOUT_EN undefined:
  - No counter logic.
  - timeout is tied to 0, and COLLECT waits indefinitely.

## Test plan
- Correct PIN: card_in=1, keys 1,2,3,4, enter → pin_valid=1 with pin_bcd=0x1234; pin_ready=1 → WAIT_RESULT; pin_ok → DONE; card_in=0 → IDLE with busy=0.
- Short PIN and clear: keys 7,8, enter → no pin_valid; clear → digit_count=0; then 5 digits 1..5 → pin_bcd=0x1234, with the 5th digit ignored.
- Lockout: three rounds of 0000 + enter + pin_reject → attempts_left 2, 1, 0; after the third round card_retain=1 in LOCKED; card_in toggling has no effect; rst_n=0 → all reset values.
- Handshake stall: hold pin_ready=0 for 10 cycles → pin_valid stays 1 and pin_bcd stays constant; pin_ready=1 → pin_valid=0 on the next cycle.
- Priority: card_in=0 in the same cycle as pin_ok → IDLE, not DONE. pin_ok and pin_reject together → DONE, with attempts_left unchanged.
- Timeout (PIN_TIMEOUT_EN, TIMEOUT=8): one digit, then no keys → timeout pulses exactly once, 8 cycles after the last strobe, and the state returns to IDLE; a key at cycle 7 restarts the count.

Source files
------------

// File: rtl/pin_entry_ctrl.sv
// Keypad PIN collector: gathers BCD digits, hands the PIN downstream over valid/ready,
// tracks verdicts and retains the card. Optional idle timeout enabled by `define PIN_TIMEOUT_EN.
module pin_entry_ctrl #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                card_in,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic                pin_ready,
  input  logic                pin_ok,
  input  logic                pin_reject,
  output logic                pin_valid,
  output logic [4*DIGITS-1:0] pin_bcd,
  output logic [3:0]          digit_count,
  output logic [1:0]          attempts_left,
  output logic                card_retain,
  output logic                timeout,
  output logic                busy
);

  localparam int unsigned PinW     = 4 * DIGITS;
  localparam logic [3:0]  DigitMax = 4'(DIGITS);
  localparam logic [1:0]  AttInit  = 2'(MAX_TRIES);
  localparam logic [3:0]  KeyClear = 4'hA;
  localparam logic [3:0]  KeyEnter = 4'hB;
  localparam logic [3:0]  KeyCancel = 4'hC;

  typedef enum logic [2:0] {
    StIdle, StCollect, StPresent, StWait, StDone, StLocked
  } state_e;

  state_e          state_q, state_d;
  logic [PinW-1:0] pin_q, pin_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      att_q, att_d;
  logic            pin_valid_q, pin_valid_d;
  logic            busy_q, busy_d;
  logic            retain_q, retain_d;
  logic [PinW+3:0] shifted;

  assign shifted = {pin_q, key_code};

`ifdef PIN_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  logic [IdleW-1:0] idle_q, idle_d;
  logic             timeout_q, timeout_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pin_q       <= '0;
      cnt_q       <= '0;
      att_q       <= AttInit;
      pin_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      retain_q    <= 1'b0;
`ifdef PIN_TIMEOUT_EN
      idle_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pin_q       <= pin_d;
      cnt_q       <= cnt_d;
      att_q       <= att_d;
      pin_valid_q <= pin_valid_d;
      busy_q      <= busy_d;
      retain_q    <= retain_d;
`ifdef PIN_TIMEOUT_EN
      idle_q      <= idle_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pin_d   = pin_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
`ifdef PIN_TIMEOUT_EN
    idle_d    = '0;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (card_in) state_d = StCollect;
      end
      StCollect: begin
        // Card removal outranks keys and the idle timeout.
        if (!card_in) begin
          state_d = StIdle;
        end else if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (cnt_q < DigitMax) begin
              pin_d = shifted[PinW-1:0];
              cnt_d = cnt_q + 4'd1;
            end
          end else if (key_code == KeyClear) begin
            pin_d = '0;
            cnt_d = '0;
          end else if (key_code == KeyEnter) begin
            if (cnt_q == DigitMax) state_d = StPresent;
          end else if (key_code == KeyCancel) begin
            state_d = StIdle;
          end
`ifdef PIN_TIMEOUT_EN
        end else if (idle_q == IdleW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          idle_d = idle_q + 1'b1;
`endif
        end
      end
      StPresent: begin
        if (!card_in) state_d = StIdle;
        else if (pin_ready) state_d = StWait;
      end
      StWait: begin
        if (!card_in) begin
          state_d = StIdle;
        end else if (pin_ok) begin
          state_d = StDone;
          pin_d   = '0;
          cnt_d   = '0;
        end else if (pin_reject) begin
          att_d   = att_q - 2'd1;
          pin_d   = '0;
          cnt_d   = '0;
          state_d = (att_q == 2'd1) ? StLocked : StCollect;
        end
      end
      StDone: begin
        if (!card_in) state_d = StIdle;
      end
      StLocked: ;
      default: state_d = StIdle;
    endcase
    // The buffer and retry budget are already fresh on the first IDLE cycle.
    if (state_d == StIdle) begin
      pin_d = '0;
      cnt_d = '0;
      att_d = AttInit;
    end
  end

  always_comb begin
    pin_valid_d = (state_d == StPresent);
    busy_d      = (state_d == StCollect) || (state_d == StPresent) || (state_d == StWait);
    retain_d    = (state_d == StLocked);
  end

  assign pin_valid     = pin_valid_q;
  assign pin_bcd       = pin_q;
  assign digit_count   = cnt_q;
  assign attempts_left = att_q;
  assign card_retain   = retain_q;
  assign busy          = busy_q;
`ifdef PIN_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
